// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the IFU/LSU memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_RESP
   } arb_state_e;

   typedef enum logic {
      OWN_IFU,
      OWN_LSU
   } arb_own_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic              ifu_req;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_gnt;
   logic              ifu_rvalid;
   logic [DATA_W-1:0] ifu_rdata;

   logic              lsu_req;
   logic              lsu_wen;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_wdata;
   logic [MASK_W-1:0] lsu_wmask;
   logic              lsu_gnt;
   logic              lsu_rvalid;
   logic [DATA_W-1:0] lsu_rdata;

   logic              err;

   logic              mem_ren;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;

   modport slave (
      input  ifu_req, ifu_addr,
      input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
      input  mem_rdata, mem_valid,
      output ifu_gnt, ifu_rvalid, ifu_rdata,
      output lsu_gnt, lsu_rvalid, lsu_rdata,
      output err,
      output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
   );

   modport master (
      output ifu_req, ifu_addr,
      output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
      output mem_rdata, mem_valid,
      input  ifu_gnt, ifu_rvalid, ifu_rdata,
      input  lsu_gnt, lsu_rvalid, lsu_rdata,
      input  err,
      input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IFU and LSU requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise LSU has fixed priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic     ifu_req,
   input  logic     lsu_req,
`ifdef MEM_ARB_RR_EN
   input  arb_own_e last_own,
`endif
   output logic     ifu_win,
   output logic     lsu_win
);

   always_comb begin
      ifu_win = 1'b0;
      lsu_win = 1'b0;
      if (ifu_req && lsu_req) begin
`ifdef MEM_ARB_RR_EN
         // Whoever was not served last takes the tie.
         if (last_own == OWN_LSU) begin
            ifu_win = 1'b1;
         end else begin
            lsu_win = 1'b1;
         end
`else
         lsu_win = 1'b1;
`endif
      end else begin
         ifu_win = ifu_req;
         lsu_win = lsu_req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// One-outstanding-transaction arbiter between IFU and LSU for the shared sram port,
// with a BUSY timeout that completes hung accesses with err. MEM_ARB_RR_EN enables round-robin ties.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   arb_state_e        state_reg;
   arb_own_e          owner_reg;
   logic [7:0]        cnt_reg;

   logic              mem_ren_reg;
   logic              mem_wen_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [MASK_W-1:0] mem_wmask_reg;

   logic              ifu_rvalid_reg;
   logic [DATA_W-1:0] ifu_rdata_reg;
   logic              lsu_rvalid_reg;
   logic [DATA_W-1:0] lsu_rdata_reg;
   logic              err_reg;

   logic              ifu_win;
   logic              lsu_win;
   logic              done;
   logic [DATA_W-1:0] cap_data;

`ifdef MEM_ARB_RR_EN
   arb_own_e          last_reg;
`endif

   mem_arb_pick u_pick (
      .ifu_req  (bus.ifu_req),
      .lsu_req  (bus.lsu_req),
`ifdef MEM_ARB_RR_EN
      .last_own (last_reg),
`endif
      .ifu_win  (ifu_win),
      .lsu_win  (lsu_win)
   );

   // Grants are combinational but suppressed while reset is held.
   assign bus.ifu_gnt = rst && (state_reg == ARB_IDLE) && ifu_win;
   assign bus.lsu_gnt = rst && (state_reg == ARB_IDLE) && lsu_win;

   // Timeout and a valid in the same cycle both end BUSY; valid decides err.
   assign done     = bus.mem_valid || (cnt_reg == TO_LAST);
   assign cap_data = (bus.mem_valid && !mem_wen_reg) ? bus.mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= ARB_IDLE;
         owner_reg      <= OWN_LSU;
         cnt_reg        <= '0;
         mem_ren_reg    <= 1'b0;
         mem_wen_reg    <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         mem_wmask_reg  <= '0;
         ifu_rvalid_reg <= 1'b0;
         ifu_rdata_reg  <= '0;
         lsu_rvalid_reg <= 1'b0;
         lsu_rdata_reg  <= '0;
         err_reg        <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_reg       <= OWN_LSU;
`endif
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (lsu_win) begin
                  owner_reg     <= OWN_LSU;
                  mem_ren_reg   <= !bus.lsu_wen;
                  mem_wen_reg   <= bus.lsu_wen;
                  mem_addr_reg  <= bus.lsu_addr;
                  mem_wdata_reg <= bus.lsu_wdata;
                  mem_wmask_reg <= bus.lsu_wmask;
                  cnt_reg       <= '0;
                  state_reg     <= ARB_BUSY;
`ifdef MEM_ARB_RR_EN
                  last_reg      <= OWN_LSU;
`endif
               end else if (ifu_win) begin
                  owner_reg     <= OWN_IFU;
                  mem_ren_reg   <= 1'b1;
                  mem_wen_reg   <= 1'b0;
                  mem_addr_reg  <= bus.ifu_addr;
                  mem_wdata_reg <= '0;
                  mem_wmask_reg <= '0;
                  cnt_reg       <= '0;
                  state_reg     <= ARB_BUSY;
`ifdef MEM_ARB_RR_EN
                  last_reg      <= OWN_IFU;
`endif
               end
            end

            ARB_BUSY: begin
               cnt_reg <= cnt_reg + 8'd1;
               if (done) begin
                  err_reg <= !bus.mem_valid;
                  if (owner_reg == OWN_LSU) begin
                     lsu_rvalid_reg <= 1'b1;
                     lsu_rdata_reg  <= cap_data;
                  end else begin
                     ifu_rvalid_reg <= 1'b1;
                     ifu_rdata_reg  <= cap_data;
                  end
                  mem_ren_reg   <= 1'b0;
                  mem_wen_reg   <= 1'b0;
                  mem_addr_reg  <= '0;
                  mem_wdata_reg <= '0;
                  mem_wmask_reg <= '0;
                  state_reg     <= ARB_RESP;
               end
            end

            ARB_RESP: begin
               ifu_rvalid_reg <= 1'b0;
               ifu_rdata_reg  <= '0;
               lsu_rvalid_reg <= 1'b0;
               lsu_rdata_reg  <= '0;
               err_reg        <= 1'b0;
               cnt_reg        <= '0;
               state_reg      <= ARB_IDLE;
            end

            default: state_reg <= ARB_IDLE;
         endcase
      end
   end

   assign bus.mem_ren    = mem_ren_reg;
   assign bus.mem_wen    = mem_wen_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.mem_wdata  = mem_wdata_reg;
   assign bus.mem_wmask  = mem_wmask_reg;
   assign bus.ifu_rvalid = ifu_rvalid_reg;
   assign bus.ifu_rdata  = ifu_rdata_reg;
   assign bus.lsu_rvalid = lsu_rvalid_reg;
   assign bus.lsu_rdata  = lsu_rdata_reg;
   assign bus.err        = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus hand sequences for ties,
// timeout, mid-BUSY reset and stray mem_valid pulses.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        is_lsu;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  wmask;
      logic [31:0] mrdata;
      int          lat;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.ifu_req   = 1'b0;
      bus.ifu_addr  = '0;
      bus.lsu_req   = 1'b0;
      bus.lsu_wen   = 1'b0;
      bus.lsu_addr  = '0;
      bus.lsu_wdata = '0;
      bus.lsu_wmask = '0;
      bus.mem_rdata = '0;
      bus.mem_valid = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk1({tag, "_ifu_gnt"}, bus.ifu_gnt, 1'b0);
      chk1({tag, "_lsu_gnt"}, bus.lsu_gnt, 1'b0);
      chk1({tag, "_ifu_rvalid"}, bus.ifu_rvalid, 1'b0);
      chk1({tag, "_lsu_rvalid"}, bus.lsu_rvalid, 1'b0);
      chk({tag, "_ifu_rdata"}, bus.ifu_rdata, 32'h0);
      chk({tag, "_lsu_rdata"}, bus.lsu_rdata, 32'h0);
      chk1({tag, "_err"}, bus.err, 1'b0);
      chk1({tag, "_mem_ren"}, bus.mem_ren, 1'b0);
      chk1({tag, "_mem_wen"}, bus.mem_wen, 1'b0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
      chk({tag, "_mem_wmask"}, {24'h0, bus.mem_wmask}, 32'h0);
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      logic exp_ren;
      exp_ren = v.is_lsu ? !v.wen : 1'b1;
      if (v.is_lsu) begin
         bus.lsu_req   = 1'b1;
         bus.lsu_wen   = v.wen;
         bus.lsu_addr  = v.addr;
         bus.lsu_wdata = v.wdata;
         bus.lsu_wmask = v.wmask;
      end else begin
         bus.ifu_req  = 1'b1;
         bus.ifu_addr = v.addr;
      end
      #1;
      chk1("vec_ifu_gnt", bus.ifu_gnt, !v.is_lsu);
      chk1("vec_lsu_gnt", bus.lsu_gnt, v.is_lsu);
      tick();
      // Scramble the requester payload so only the latched copy can be right.
      bus.ifu_req   = 1'b0;
      bus.lsu_req   = 1'b0;
      bus.ifu_addr  = 32'h0BAD0BAD;
      bus.lsu_addr  = 32'h0BAD0BAD;
      bus.lsu_wdata = 32'hFFFF0000;
      bus.lsu_wmask = 8'hAA;
      for (int c = 1; c <= v.lat; c++) begin
         chk1("vec_mem_ren", bus.mem_ren, exp_ren);
         chk1("vec_mem_wen", bus.mem_wen, v.is_lsu & v.wen);
         chk("vec_mem_addr", bus.mem_addr, v.addr);
         if (v.is_lsu && v.wen) begin
            chk("vec_mem_wdata", bus.mem_wdata, v.wdata);
            chk("vec_mem_wmask", {24'h0, bus.mem_wmask}, {24'h0, v.wmask});
         end
         chk1("vec_no_early_rvalid", bus.ifu_rvalid | bus.lsu_rvalid, 1'b0);
         if (c == v.lat) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = v.mrdata;
         end
         tick();
      end
      bus.mem_valid = 1'b0;
      bus.mem_rdata = '0;
      chk1("vec_ifu_rvalid", bus.ifu_rvalid, !v.is_lsu);
      chk1("vec_lsu_rvalid", bus.lsu_rvalid, v.is_lsu);
      chk("vec_rdata", v.is_lsu ? bus.lsu_rdata : bus.ifu_rdata, v.exp_rdata);
      chk1("vec_err", bus.err, 1'b0);
      chk1("vec_resp_strobes", bus.mem_ren | bus.mem_wen, 1'b0);
      tick();
      chk1("vec_idle_rvalid", bus.ifu_rvalid | bus.lsu_rvalid, 1'b0);
      chk("vec_idle_rdata", bus.ifu_rdata | bus.lsu_rdata, 32'h0);
      $display("TXN vec%0d %s wen=%0b addr=%h lat=%0d exp_rdata=%h errors=%0d",
               idx, v.is_lsu ? "LSU" : "IFU", v.wen, v.addr, v.lat, v.exp_rdata, errors);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h80000000, 32'h0,        8'h00, 32'hDEADBEEF, 1, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b1, 32'h80000010, 32'h12345678, 8'h0F, 32'hFFFFFFFF, 3, 32'h00000000};
      vecs[2] = '{1'b1, 1'b0, 32'h80000020, 32'h0,        8'h00, 32'hCAFEF00D, 2, 32'hCAFEF00D};
      vecs[3] = '{1'b0, 1'b0, 32'h00000004, 32'h0,        8'h00, 32'h00000013, 5, 32'h00000013};
      vecs[4] = '{1'b1, 1'b1, 32'h8000FFFC, 32'hA5A5A5A5, 8'hF0, 32'h77777777, 1, 32'h00000000};

      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      // Requests during reset must not be granted.
      bus.ifu_req = 1'b1;
      bus.lsu_req = 1'b1;
      #1;
      chk_quiet("reset");
      idle_inputs();
      tick();
      rst = 1'b1;
      #1;
      chk_quiet("post_reset");

      for (int i = 0; i < 5; i++) begin
         run_txn(vecs[i], i);
      end

      // Reset in the second BUSY cycle drops the transaction silently.
      bus.lsu_req   = 1'b1;
      bus.lsu_wen   = 1'b1;
      bus.lsu_addr  = 32'h80000040;
      bus.lsu_wdata = 32'h0F0F0F0F;
      bus.lsu_wmask = 8'hFF;
      #1;
      chk1("rstmid_gnt", bus.lsu_gnt, 1'b1);
      tick();
      bus.lsu_req = 1'b0;
      chk1("rstmid_busy1_wen", bus.mem_wen, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      bus.lsu_req = 1'b1;
      #1;
      chk_quiet("rstmid");
      idle_inputs();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         bus.mem_valid = 1'b1;
         bus.mem_rdata = 32'h99999999;
         tick();
         chk1("rstmid_no_rvalid", bus.ifu_rvalid | bus.lsu_rvalid, 1'b0);
         chk1("rstmid_no_err", bus.err, 1'b0);
      end
      bus.mem_valid = 1'b0;
      $display("TXN rstmid dropped LSU write, errors=%0d", errors);

      // Both requesters hold req continuously; first tie after reset.
      bus.ifu_req  = 1'b1;
      bus.ifu_addr = 32'h80001000;
      bus.lsu_req  = 1'b1;
      bus.lsu_wen  = 1'b0;
      bus.lsu_addr = 32'h80002000;
      for (int i = 0; i < 6; i++) begin
         logic exp_lsu;
`ifdef MEM_ARB_RR_EN
         exp_lsu = (i % 2) == 1;
`else
         exp_lsu = 1'b1;
`endif
         #1;
         chk1("tie_ifu_gnt", bus.ifu_gnt, !exp_lsu);
         chk1("tie_lsu_gnt", bus.lsu_gnt, exp_lsu);
         tick();
         chk("tie_mem_addr", bus.mem_addr, exp_lsu ? 32'h80002000 : 32'h80001000);
         bus.mem_valid = 1'b1;
         bus.mem_rdata = 32'h100 + i;
         tick();
         bus.mem_valid = 1'b0;
         chk1("tie_ifu_rvalid", bus.ifu_rvalid, !exp_lsu);
         chk1("tie_lsu_rvalid", bus.lsu_rvalid, exp_lsu);
         chk("tie_rdata", exp_lsu ? bus.lsu_rdata : bus.ifu_rdata, 32'h100 + i);
         tick();
         $display("TXN tie%0d winner=%s errors=%0d", i, exp_lsu ? "LSU" : "IFU", errors);
      end
      idle_inputs();

      // Timeout: mem_valid never arrives.
      bus.ifu_req  = 1'b1;
      bus.ifu_addr = 32'h80000100;
      #1;
      chk1("to_gnt", bus.ifu_gnt, 1'b1);
      tick();
      bus.ifu_req = 1'b0;
      for (int c = 2; c <= TO; c++) tick();
      chk1("to_pre_rvalid", bus.ifu_rvalid, 1'b0);
      chk1("to_pre_ren", bus.mem_ren, 1'b1);
      tick();
      chk1("to_rvalid", bus.ifu_rvalid, 1'b1);
      chk1("to_err", bus.err, 1'b1);
      chk("to_rdata", bus.ifu_rdata, 32'h0);
      chk1("to_ren_off", bus.mem_ren, 1'b0);
      tick();
      chk1("to_idle_rvalid", bus.ifu_rvalid, 1'b0);
      chk1("to_idle_err", bus.err, 1'b0);
      $display("TXN timeout IFU err completion errors=%0d", errors);

      // mem_valid in the very cycle the counter expires wins over the timeout.
      bus.ifu_req  = 1'b1;
      bus.ifu_addr = 32'h80000200;
      #1;
      chk1("toedge_gnt", bus.ifu_gnt, 1'b1);
      tick();
      bus.ifu_req = 1'b0;
      for (int c = 2; c <= TO; c++) tick();
      bus.mem_valid = 1'b1;
      bus.mem_rdata = 32'h55AA55AA;
      tick();
      bus.mem_valid = 1'b0;
      chk1("toedge_rvalid", bus.ifu_rvalid, 1'b1);
      chk1("toedge_err", bus.err, 1'b0);
      chk("toedge_rdata", bus.ifu_rdata, 32'h55AA55AA);
      tick();
      $display("TXN timeout-edge IFU valid wins errors=%0d", errors);

      // Stray mem_valid in IDLE.
      bus.mem_valid = 1'b1;
      bus.mem_rdata = 32'h11111111;
      tick();
      bus.mem_valid = 1'b0;
      chk_quiet("idle_valid");

      // Stray mem_valid in RESP.
      bus.lsu_req  = 1'b1;
      bus.lsu_wen  = 1'b0;
      bus.lsu_addr = 32'h80000300;
      #1;
      chk1("respv_gnt", bus.lsu_gnt, 1'b1);
      tick();
      bus.lsu_req   = 1'b0;
      bus.mem_valid = 1'b1;
      bus.mem_rdata = 32'h22222222;
      tick();
      chk1("respv_rvalid", bus.lsu_rvalid, 1'b1);
      chk("respv_rdata", bus.lsu_rdata, 32'h22222222);
      bus.mem_rdata = 32'h33333333;
      tick();
      bus.mem_valid = 1'b0;
      chk_quiet("respv_after");
      bus.lsu_req = 1'b1;
      #1;
      chk1("respv_idle_gnt", bus.lsu_gnt, 1'b1);
      tick();
      bus.lsu_req   = 1'b0;
      bus.mem_valid = 1'b1;
      tick();
      bus.mem_valid = 1'b0;
      tick();
      $display("TXN stray mem_valid IDLE/RESP errors=%0d", errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
